fp_divider: RTL

FP_DIVIDER -- requirements
Module: fp_divider

---
 rtl/fp_divider.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fp_divider.sv
// fp_divider: IEEE-754 single-precision divider with a fixed 28-cycle start-to-done latency.
// Define FP_DIV_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates toward zero.
module fp_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] S,
  output logic [3:0]  flags
);

`ifdef FP_DIV_ROUND_NEAREST_EN
  localparam bit RoundNearest = 1'b1;
`else
  localparam bit RoundNearest = 1'b0;
`endif

  localparam logic [4:0] LastIter = 5'd25;

  // IDLE wait for start | CALC one quotient bit per cycle | NORM normalise | DONE round, classify, publish
  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  state_t            state_q;
  logic [4:0]        cnt_q;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [23:0]       dvs_q;
  logic [24:0]       rem_q;
  logic [25:0]       quo_q;
  logic signed [9:0] exp_q;
  logic [22:0]       frac_q;
  logic              grd_q;
  logic              rnd_q;
  logic              stk_q;
  logic              busy_q;
  logic              done_q;
  logic [31:0]       s_q;
  logic [3:0]        flags_q;

  logic signed [9:0] exp_start_d;
  logic [25:0]       trial_d;
  logic              ge_d;
  logic [24:0]       rem_d;

  always_comb begin
    exp_start_d = $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]}) + 10'sd127;
    trial_d     = {1'b0, rem_q} - {2'b00, dvs_q};
    ge_d        = ~trial_d[25];
    rem_d       = ge_d ? (trial_d[24:0] << 1) : (rem_q << 1);
  end

  logic              a_nan, a_inf, a_zero;
  logic              b_nan, b_inf, b_zero;
  logic              sign_d;
  logic              round_up_d;
  logic [23:0]       frac_rnd_d;
  logic signed [9:0] exp_rnd_d;
  logic [31:0]       s_d;
  logic [3:0]        flags_d;

  // Exponent field zero covers both true zero and denormals, which are flushed to zero.
  always_comb begin
    a_zero     = (a_q[30:23] == 8'h00);
    a_nan      = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    a_inf      = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    b_zero     = (b_q[30:23] == 8'h00);
    b_nan      = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    b_inf      = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    sign_d     = a_q[31] ^ b_q[31];
    round_up_d = RoundNearest & grd_q & (rnd_q | stk_q | frac_q[0]);
    frac_rnd_d = {1'b0, frac_q} + {23'd0, round_up_d};
    exp_rnd_d  = exp_q + $signed({9'd0, frac_rnd_d[23]});
    s_d        = {sign_d, exp_rnd_d[7:0], frac_rnd_d[22:0]};
    flags_d    = 4'b0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      s_d     = 32'h7FC0_0000;
      flags_d = 4'b1000;
    end else if (b_zero && !a_inf) begin
      s_d     = {sign_d, 8'hFF, 23'd0};
      flags_d = 4'b0100;
    end else if (a_inf) begin
      s_d     = {sign_d, 8'hFF, 23'd0};
    end else if (b_inf || a_zero) begin
      s_d     = {sign_d, 31'd0};
    end else if (exp_rnd_d >= 10'sd255) begin
      s_d     = {sign_d, 8'hFF, 23'd0};
      flags_d = 4'b0010;
    end else if (exp_rnd_d <= 10'sd0) begin
      s_d     = {sign_d, 31'd0};
      flags_d = 4'b0001;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      dvs_q   <= 24'd0;
      rem_q   <= 25'd0;
      quo_q   <= 26'd0;
      exp_q   <= 10'sd0;
      frac_q  <= 23'd0;
      grd_q   <= 1'b0;
      rnd_q   <= 1'b0;
      stk_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= 32'd0;
      flags_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            dvs_q   <= {1'b1, B[22:0]};
            rem_q   <= {2'b01, A[22:0]};
            quo_q   <= 26'd0;
            exp_q   <= exp_start_d;
            cnt_q   <= LastIter;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[24:0], ge_d};
          if (cnt_q == 5'd0) begin
            state_q <= NORM;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        NORM: begin
          // Quotient lies in (0.5, 2): a clear MSB means one left shift.
          if (quo_q[25]) begin
            frac_q <= quo_q[24:2];
            grd_q  <= quo_q[1];
            rnd_q  <= quo_q[0];
          end else begin
            frac_q <= quo_q[23:1];
            grd_q  <= quo_q[0];
            rnd_q  <= 1'b0;
            exp_q  <= exp_q - 10'sd1;
          end
          stk_q   <= |rem_q;
          state_q <= DONE;
        end
        DONE: begin
          s_q     <= s_d;
          flags_q <= flags_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign S     = s_q;
  assign flags = flags_q;

endmodule
